// File: rtl/nw_dir_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback direction store:
// direction symbols, sequencer states and the grid-to-RAM address mapping.
package nw_dir_pkg;

  localparam logic [2:0] SYM_DIAG = 3'b100;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b001;
  localparam logic [2:0] SYM_END  = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    TB_RD,
    TB_WAIT,
    TB_OUT
  } state_t;

  // Row-major cell address; the caller narrows the exact result to ADDR_W.
  function automatic int cell_addr(input int row, input int col, input int m);
    return row * (m + 1) + col;
  endfunction

endpackage

// File: rtl/nw_dir_sdp_ram.sv
// Simple dual-port storage for the direction matrix: one write and one
// synchronous read per cycle, one cycle of read latency.
module nw_dir_sdp_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nw_direction_store.sv
// Direction-matrix manager: border initialisation, fill-phase writes from the
// score engine, and a traceback walker streaming the path over valid/ready.
module nw_direction_store
  import nw_dir_pkg::*;
#(
  parameter int N      = 128,
  parameter int M      = 128,
  parameter int IDX_W  = $clog2(((N > M) ? N : M) + 1),
  parameter int ADDR_W = $clog2((N + 1) * (M + 1)),
  parameter int SYM_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_init,
  output logic             init_done,
  input  logic             en_ins,
  input  logic [IDX_W-1:0] i,
  input  logic [IDX_W-1:0] j,
  input  logic [SYM_W-1:0] symbol_in,
  output logic             ins_err,
  input  logic             start_trace,
  output logic             tb_valid,
  input  logic             tb_ready,
  output logic [SYM_W-1:0] tb_symbol,
  output logic [IDX_W-1:0] tb_i,
  output logic [IDX_W-1:0] tb_j,
  output logic             tb_last,
  output logic             tb_err,
  output logic             busy
);

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   raddr;
  logic [SYM_W-1:0]    wdata;
  logic [SYM_W-1:0]    rdata;
  logic                fill_ok;
  logic                sym_err;
  logic                sym_last;

  assign fill_ok = en_ins && (state == IDLE) &&
                   (i != '0) && (int'(i) <= N) &&
                   (j != '0) && (int'(j) <= M);

  // Init walks a single counter: 0 -> (0,0), 1..M -> row 0, M+1..M+N -> column 0.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    we    = 1'b0;
    waddr = '0;
    wdata = SYM_END;
    if (state == INIT) begin
      we = 1'b1;
      if (init_cnt == '0) begin
        waddr = '0;
        wdata = SYM_END;
      end else if (int'(init_cnt) <= M) begin
        waddr = init_cnt;
        wdata = SYM_LEFT;
      end else begin
        waddr = ADDR_W'(cell_addr(int'(init_cnt) - M, 0, M));
        wdata = SYM_UP;
      end
    end else if (fill_ok) begin
      we    = 1'b1;
      waddr = ADDR_W'(cell_addr(int'(i), int'(j), M));
      wdata = symbol_in;
    end
  end

  // The read address always tracks the walker position; only TB_RD consumes it.
  assign raddr = ADDR_W'(cell_addr(int'(tb_i), int'(tb_j), M));

  nw_dir_sdp_ram #(
    .DEPTH  ((N + 1) * (M + 1)),
    .ADDR_W (ADDR_W),
    .DW     (SYM_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    sym_err = 1'b0;
    case (rdata)
      SYM_DIAG: sym_err = (tb_i == '0) || (tb_j == '0);
      SYM_UP:   sym_err = (tb_i == '0);
      SYM_LEFT: sym_err = (tb_j == '0);
      SYM_END:  sym_err = (tb_i != '0) || (tb_j != '0);
      default:  sym_err = 1'b1;
    endcase
  end

  assign sym_last = sym_err || (rdata == SYM_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      init_cnt  <= '0;
      init_done <= 1'b0;
      ins_err   <= 1'b0;
      tb_valid  <= 1'b0;
      tb_last   <= 1'b0;
      tb_err    <= 1'b0;
      busy      <= 1'b0;
      tb_symbol <= '0;
      tb_i      <= '0;
      tb_j      <= '0;
    end else begin
      init_done <= 1'b0;
      ins_err   <= en_ins && !fill_ok;
      case (state)
        IDLE: begin
          if (start_init) begin
            state    <= INIT;
            init_cnt <= '0;
            busy     <= 1'b1;
          end else if (start_trace) begin
            state <= TB_RD;
            tb_i  <= IDX_W'(N);
            tb_j  <= IDX_W'(M);
            busy  <= 1'b1;
          end
        end
        INIT: begin
          if (int'(init_cnt) == N + M) begin
            state     <= IDLE;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ADDR_W'(1);
          end
        end
        TB_RD:   state <= TB_WAIT;
        TB_WAIT: begin
          tb_symbol <= rdata;
          tb_err    <= sym_err;
          tb_last   <= sym_last;
          tb_valid  <= 1'b1;
          state     <= TB_OUT;
        end
        TB_OUT: begin
          // Error elements are flagged last, so position only moves on legal steps.
          if (tb_ready) begin
            tb_valid <= 1'b0;
            if (tb_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= TB_RD;
              case (tb_symbol)
                SYM_DIAG: begin
                  tb_i <= tb_i - IDX_W'(1);
                  tb_j <= tb_j - IDX_W'(1);
                end
                SYM_UP:   tb_i <= tb_i - IDX_W'(1);
                SYM_LEFT: tb_j <= tb_j - IDX_W'(1);
                default:  ;
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nw_direction_store.md
Name: nw_direction_store

Overview:
- Parametrised successor of the Needleman-Wunsch direction-memory manager.
- Holds the traceback direction matrix for a rectangular (N+1)x(M+1) score grid, with non-square sequences allowed.
- Contains an autonomous border-initialisation sequencer, a fill-phase write port driven by the score engine, and an autonomous traceback walker.
- The walker streams the alignment path from (N,M) to (0,0) over a valid/ready handshake to the alignment output stage.

Parameters:
- N, 128: length of sequence A (rows 1..N).
- M, 128: length of sequence B (columns 1..M).
- IDX_W, $clog2(max(N,M)+1): width of the i and j indices.
- ADDR_W, $clog2((N+1)*(M+1)): RAM address width.
- SYM_W, 3: direction symbol width, fixed at 3. Encoding: 3'b100 DIAG, 3'b010 UP, 3'b001 LEFT, 3'b000 END.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start_init  in  1  pulse: begin border initialisation.
- init_done  out  1  one-cycle pulse: border written.
- en_ins  in  1  fill-phase write strobe.
- i  in  IDX_W  fill row index.
- j  in  IDX_W  fill column index.
- symbol_in  in  SYM_W  fill symbol.
- ins_err  out  1  one-cycle pulse: rejected fill write.
- start_trace  in  1  pulse: begin traceback.
- tb_valid  out  1  path element valid.
- tb_ready  in  1  consumer ready.
- tb_symbol  out  SYM_W  direction at the current cell.
- tb_i  out  IDX_W  current row.
- tb_j  out  IDX_W  current column.
- tb_last  out  1  final element of the path.
- tb_err  out  1  traceback aborted on a corrupt symbol; qualified by tb_valid.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Address mapping: addr = i*(M+1)+j, computed at ADDR_W width with no truncation.
- RAM: simple dual-port, 1 write and 1 synchronous read per cycle, 1-cycle read latency. Contents are not cleared by rst.
- FSM states: IDLE, INIT, TB_RD, TB_WAIT, TB_OUT.
- Reset: state IDLE. All outputs 0: init_done, ins_err, tb_valid, tb_last, tb_err, busy, tb_symbol, tb_i, tb_j.
- IDLE + start_init goes to INIT. start_init wins over a simultaneous start_trace, and start_trace is then dropped.
- IDLE + start_trace (no start_init) goes to TB_RD with tb_i=N, tb_j=M.
- INIT writes one cell per cycle:
  - (0,0)=END.
  - (0,1..M)=LEFT.
  - (1..N,0)=UP.
  - Total N+M+1 cycles.
  - init_done pulses the cycle after the last write, with the return to IDLE.
- Fill writes:
  - Accepted only in IDLE, and only when 1<=i<=N and 1<=j<=M. An accepted write lands on the next edge.
  - Out-of-range writes, or en_ins in any state other than IDLE: no write, and ins_err pulses the next cycle.
  - en_ins in the same cycle as start_init or start_trace is still honoured if in range.
- TB_RD: issue a read of addr(tb_i,tb_j).
- TB_WAIT: data returns; register it into tb_symbol.
- TB_OUT:
  - tb_valid=1. tb_symbol, tb_i, tb_j, tb_last, tb_err are held stable until tb_valid&&tb_ready.
  - tb_valid is first asserted 2 cycles after start_trace is sampled.
  - On handshake: DIAG decrements i and j, UP decrements i, LEFT decrements j, then back to TB_RD. Throughput is 1 element per 3 cycles.
- tb_last=1 when the symbol is END at (0,0), or on error. The handshake of the last element returns the FSM to IDLE.
- Error cases set tb_err=1 and tb_last=1:
  - symbol is not one of the four codes;
  - END at a cell other than (0,0);
  - DIAG or UP with i==0;
  - DIAG or LEFT with j==0.
  - In all error cases tb_i and tb_j are not updated.
- start_init and start_trace outside IDLE are ignored.
- Reset in any state returns to IDLE within one cycle and aborts the sequence. A partial INIT leaves its written cells in the RAM.

Decomposition:
- Package nw_dir_pkg holds:
  - symbol constants SYM_DIAG, SYM_UP, SYM_LEFT, SYM_END;
  - the FSM state encoding;
  - a cell-address function (i, j, M) -> ADDR_W.
- Sub-module nw_dir_sdp_ram(DEPTH=(N+1)*(M+1), ADDR_W, DW=SYM_W) is the storage. All sequencing stays in the top level.

Test Plan (N=4, M=3, depth 20):
- start_init -> 8 consecutive write cycles: addr 0=END, addr 1..3=LEFT, addr 4,8,12,16=UP. init_done pulses once in cycle 9; busy high for cycles 1..8.
- Init, fill every interior cell with DIAG, start_trace -> tb_valid at +2 cycles. Elements: (4,3) DIAG, (3,2) DIAG, (2,1) DIAG, (1,0) UP, (0,0) END with tb_last=1 and tb_err=0.
- Same path with tb_ready held low for 5 cycles on the element at (3,2) -> all tb_* outputs stable across the stall, and there are no duplicate or dropped elements.
- en_ins with (i=0,j=2), with (5,1), and during INIT -> no RAM change, and ins_err pulses once for each.
- Write symbol 3'b110 at (4,3), then start_trace -> first element has tb_symbol=3'b110, tb_err=1, tb_last=1. After the handshake, busy=0.
- Assert rst during TB_OUT at (2,1) -> next cycle: tb_valid=0, busy=0, state IDLE. A new start_trace restarts at (4,3) with the RAM content intact.
